// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//
// Hardware LIFO that services the push/pop strobes from the opcode decoder.
// Storage is registered. The top-of-stack read is combinational, so a pop
// can write topdata back to the register file in the same cycle that the pop
// is asserted.
//
// Parameters:
//   DATA_WIDTH  width of each stack entry
//   DEPTH       number of entries (power of two, >= 2)
//   PTR_WIDTH   pointer width, $clog2(DEPTH); count is PTR_WIDTH+1 bits wide
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   push       push strobe
//   pop        pop strobe
//   pushdata   value to push (or replacement value on push+pop)
//   topdata    current top entry, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: push attempted while full (push alone)
//   underflow  sticky: pop attempted while empty
//
// Optional feature (macro STACK_PEEK_EN):
//   peekidx    input, depth below the top to inspect (0 = top)
//   peekdata   output, mem[count-1-peekidx] when peekidx < count, else 0
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] pushdata,
`ifdef STACK_PEEK_EN
  input  logic [PTR_WIDTH-1:0]  peekidx,
  output logic [DATA_WIDTH-1:0] peekdata,
`endif
  output logic [DATA_WIDTH-1:0] topdata,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] C_ONE   = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic [PTR_WIDTH-1:0]  w_top_idx;
  logic                  w_mem_we;
  logic [PTR_WIDTH-1:0]  w_mem_waddr;
  logic [PTR_WIDTH:0]    w_count_nxt;
  logic                  w_set_overflow;
  logic                  w_set_underflow;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  // Only meaningful when not empty; the empty case is masked on the outputs.
  assign w_top_idx = PTR_WIDTH'(r_count - C_ONE);

  // Next-state decode for pointer, flags and storage write.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt     = r_count;
    w_mem_we        = 1'b0;
    w_mem_waddr     = PTR_WIDTH'(r_count);
    w_set_overflow  = 1'b0;
    w_set_underflow = 1'b0;

    unique case ({push, pop})
      2'b10: begin
        if (w_full) begin
          w_set_overflow = 1'b1;
        end else begin
          w_mem_we    = 1'b1;
          w_count_nxt = r_count + C_ONE;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_set_underflow = 1'b1;
        end else begin
          w_count_nxt = r_count - C_ONE;
        end
      end
      2'b11: begin
        // Replace the top in place; on an empty stack this degrades to a
        // push into slot 0 and still records the failed pop.
        w_mem_we = 1'b1;
        if (w_empty) begin
          w_count_nxt     = C_ONE;
          w_set_underflow = 1'b1;
        end else begin
          w_mem_waddr = w_top_idx;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_overflow  <= r_overflow  | w_set_overflow;
      r_underflow <= r_underflow | w_set_underflow;
    end
  end

  // NOTE: the storage array is deliberately not reset. Entries at or above
  // count are never visible, so resetting the array would only add reset
  // fan-out. The write is gated by rst so strobes during reset are dropped.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_waddr] <= pushdata;
    end
  end

  assign topdata   = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef STACK_PEEK_EN
  logic [PTR_WIDTH:0]   w_peek_ext;
  logic [PTR_WIDTH-1:0] w_peek_addr;

  assign w_peek_ext  = {1'b0, peekidx};
  assign w_peek_addr = PTR_WIDTH'(r_count - C_ONE - w_peek_ext);
  assign peekdata    = (w_peek_ext < r_count) ? r_mem[w_peek_addr] : '0;
`endif

endmodule
